// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: sequences one two-channel ADC acquisition.
// Arms a trigger on channel 1. Once it fires, a fixed-length record of {ch2, ch1}
// sample pairs is streamed into the capture RAM write port. The record can be
// decimated. Completion, forced-trigger and over-range status are reported.
module adc_capture_ctrl #(
  parameter int DATA_W  = 10,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1000000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          trig_mode,
  input  logic [DATA_W-1:0]   trig_level,
  input  logic [7:0]          decim,
  input  logic [DATA_W-1:0]   ad_data_1,
  input  logic                ad_otr_1,
  input  logic [DATA_W-1:0]   ad_data_2,
  input  logic                ad_otr_2,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [2*DATA_W-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic                trig_timeout,
  output logic                ovr_1,
  output logic                ovr_2
);

  localparam int                TCNT_W    = 20;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t state, state_next;

  // Input stage: S1 holds the registered pins, S0 holds the previous ch1 sample.
  logic [DATA_W-1:0] s1_data_1, s1_data_2, s0_data_1;
  logic              s1_otr_1, s1_otr_2;

  // Configuration captured when a start is accepted.
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] level_q;
  logic [7:0]        decim_q;

  logic [TCNT_W-1:0] tcnt;
  logic [7:0]        dcnt;

  logic              accept;
  logic              edge_hit;
  logic              trig_fire;
  logic              trig_forced;
  logic              cap_write;
  logic              last_write;
  logic [ADDR_W-1:0] addr_next;

  // Register the ADC pins once and keep the previous ch1 sample for edge detection.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_data_1 <= '0;
      s1_data_2 <= '0;
      s1_otr_1  <= 1'b0;
      s1_otr_2  <= 1'b0;
      s0_data_1 <= '0;
    end else begin
      // NOTE: non-blocking assignments so S0 takes the old S1, not the new one.
      s1_data_1 <= ad_data_1;
      s1_data_2 <= ad_data_2;
      s1_otr_1  <= ad_otr_1;
      s1_otr_2  <= ad_otr_2;
      s0_data_1 <= s1_data_1;
    end
  end

  // Trigger condition on the registered ch1 samples; immediate modes fire on the first ARM cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    edge_hit = 1'b0;
    case (mode_q)
      2'd1:    edge_hit = (s0_data_1 < level_q) && (s1_data_1 >= level_q);
      2'd2:    edge_hit = (s0_data_1 >= level_q) && (s1_data_1 < level_q);
      default: edge_hit = (tcnt == '0);
    endcase
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    trig_fire   = 1'b0;
    trig_forced = 1'b0;
    cap_write   = 1'b0;
    addr_next   = wr_addr + ADDR_ONE;
    last_write  = (addr_next == ADDR_LAST);
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          accept     = 1'b1;
          state_next = ST_ARM;
        end
      end
      ST_ARM: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (edge_hit || (tcnt == TCNT_LAST)) begin
          trig_fire   = 1'b1;
          trig_forced = !edge_hit;
          state_next  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (dcnt == '0) begin
          cap_write = 1'b1;
          if (last_write) state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Counters, configuration latch, registered write port and status outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q       <= '0;
      level_q      <= '0;
      decim_q      <= '0;
      tcnt         <= '0;
      dcnt         <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      trig_timeout <= 1'b0;
      ovr_1        <= 1'b0;
      ovr_2        <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= (state == ST_DONE);
      busy  <= (state_next == ST_ARM) || (state_next == ST_CAPTURE);

      if (accept) begin
        mode_q       <= trig_mode;
        level_q      <= trig_level;
        decim_q      <= decim;
        tcnt         <= '0;
        trig_timeout <= 1'b0;
        ovr_1        <= 1'b0;
        ovr_2        <= 1'b0;
      end else if (state == ST_ARM) begin
        tcnt <= tcnt + TCNT_ONE;
      end

      if (trig_fire || cap_write) begin
        wr_en   <= 1'b1;
        wr_addr <= trig_fire ? '0 : addr_next;
        wr_data <= {s1_data_2, s1_data_1};
        dcnt    <= decim_q;
        if (s1_otr_1) ovr_1 <= 1'b1;
        if (s1_otr_2) ovr_2 <= 1'b1;
      end else if (state == ST_CAPTURE) begin
        dcnt <= dcnt - 8'd1;
      end

      if (trig_forced) trig_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: scoreboard bench for adc_capture_ctrl.
// Each capture plays a pre-generated pin pattern. A reference model scans the
// pattern for the trigger point and lists every expected write and the done
// pulse. A separate monitor compares these against what the DUT presents.
`timescale 1ns/1ps
module tb_adc_capture_ctrl;
  localparam int DATA_W  = 10;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 50;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int PAT_LEN = TIMEOUT + 4 * DEPTH + 16;

  logic                sys_clk = 1'b0;
  logic                sys_rst;
  logic                start, abort;
  logic [1:0]          trig_mode;
  logic [DATA_W-1:0]   trig_level;
  logic [7:0]          decim;
  logic [DATA_W-1:0]   ad_data_1, ad_data_2;
  logic                ad_otr_1, ad_otr_2;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [2*DATA_W-1:0] wr_data;
  logic                busy, done, trig_timeout, ovr_1, ovr_2;

  always #5 sys_clk = ~sys_clk;

  adc_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .abort(abort),
    .trig_mode(trig_mode), .trig_level(trig_level), .decim(decim),
    .ad_data_1(ad_data_1), .ad_otr_1(ad_otr_1), .ad_data_2(ad_data_2), .ad_otr_2(ad_otr_2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .trig_timeout(trig_timeout), .ovr_1(ovr_1), .ovr_2(ovr_2)
  );

  typedef struct {
    int                  cyc;
    logic [ADDR_W-1:0]   addr;
    logic [2*DATA_W-1:0] data;
  } wr_exp_t;

  wr_exp_t exp_q[$];
  int      done_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Observations of the most recent record, kept by the monitor.
  int                  first_wr   = 0;
  int                  last_wr    = 0;
  logic [2*DATA_W-1:0] first_data = '0;
  int                  last_start = 0;

  // Pin pattern of the current capture: entry 0 is the cycle before start.
  logic [DATA_W-1:0] pat1 [PAT_LEN];
  logic [DATA_W-1:0] pat2 [PAT_LEN];
  logic              potr1[PAT_LEN];
  logic              potr2[PAT_LEN];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or pulses done.
  always @(negedge sys_clk) begin : monitor
    wr_exp_t e;
    int      dc;
    if (sys_rst === 1'b0) begin
      if (wr_en) begin
        if (wr_addr == '0) begin
          first_wr   = cyc;
          first_data = wr_data;
        end
        if (wr_addr == ADDR_W'(DEPTH - 1)) last_wr = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: got addr=%0d data=%05h at cycle %0d, required no write",
                   wr_addr, wr_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc || wr_addr !== e.addr || wr_data !== e.data) begin
            failures++;
            $display("FAIL write: got cycle=%0d addr=%0d data=%05h, required cycle=%0d addr=%0d data=%05h",
                     cyc, wr_addr, wr_data, e.cyc, e.addr, e.data);
          end
        end
      end
      if (done) begin
        checks++;
        if (done_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
        end else begin
          dc = done_q.pop_front();
          if (cyc != dc) begin
            failures++;
            $display("FAIL done_cycle: got cycle %0d, required cycle %0d", cyc, dc);
          end
        end
      end
    end
  end

  task automatic drive(input int idx);
    if (idx >= 0 && idx < PAT_LEN) begin
      ad_data_1 = pat1[idx];
      ad_data_2 = pat2[idx];
      ad_otr_1  = potr1[idx];
      ad_otr_2  = potr2[idx];
    end
  endtask

  // kind: 0 ramp (ch1 = index-1, ch2 = 1023-ch1), 1 sweep 500..530, 2 constant 100, 3 random
  task automatic fill(input int kind);
    for (int i = 0; i < PAT_LEN; i++) begin
      case (kind)
        0:       pat1[i] = DATA_W'((i + DEPTH - 1) % DEPTH);
        1:       pat1[i] = DATA_W'((i <= 30) ? 500 + i : 530);
        2:       pat1[i] = DATA_W'(100);
        default: pat1[i] = DATA_W'($urandom);
      endcase
      pat2[i]  = (kind == 0) ? DATA_W'(1023 - int'(pat1[i])) : DATA_W'($urandom);
      potr1[i] = (kind == 3) && ($urandom_range(0, 199) == 0);
      potr2[i] = (kind == 3) && ($urandom_range(0, 199) == 0);
    end
  endtask

  // One capture: model the record from the pattern, push expectations, play the pins.
  // abort_addr >= 0 aborts while that address is on the write port; rst_arm >= 0
  // asserts reset after that many ARM cycles.
  task automatic run_capture(input logic [1:0] mode, input logic [DATA_W-1:0] level,
                             input logic [7:0] dec, input int abort_addr, input int rst_arm);
    int      jt, step, n_wr, s, idx, abort_cyc, end_cyc;
    bit      forced, hit, eo1, eo2;
    wr_exp_t e;
    jt = 0; forced = 0; hit = 0; eo1 = 0; eo2 = 0;
    // ARM cycle j sees current sample pat[j] and previous sample pat[j-1].
    for (int j = 1; j <= TIMEOUT; j++) begin
      if (jt == 0) begin
        case (mode)
          2'd1:    hit = (pat1[j-1] < level) && (pat1[j] >= level);
          2'd2:    hit = (pat1[j-1] >= level) && (pat1[j] < level);
          default: hit = (j == 1);
        endcase
        if (hit) jt = j;
        else if (j == TIMEOUT) begin
          jt     = j;
          forced = 1;
        end
      end
    end
    step = int'(dec) + 1;
    n_wr = (abort_addr >= 0) ? abort_addr + 1 : DEPTH;

    @(posedge sys_clk); #1;
    drive(0);
    @(posedge sys_clk); #1;
    s          = cyc;
    last_start = s;
    drive(1);
    start = 1'b1; trig_mode = mode; trig_level = level; decim = dec;

    if (rst_arm < 0) begin
      for (int k = 0; k < n_wr; k++) begin
        idx    = jt + k * step;
        e.cyc  = s + jt + 1 + k * step;
        e.addr = ADDR_W'(k);
        e.data = {pat2[idx], pat1[idx]};
        exp_q.push_back(e);
        eo1 |= potr1[idx];
        eo2 |= potr2[idx];
      end
      if (abort_addr < 0) done_q.push_back(s + jt + 1 + (DEPTH - 1) * step + 1);
    end
    abort_cyc = (abort_addr >= 0) ? s + jt + 1 + abort_addr * step : -1;
    if (rst_arm >= 0)         end_cyc = s + rst_arm;
    else if (abort_addr >= 0) end_cyc = abort_cyc + 1;
    else                      end_cyc = s + jt + 1 + (DEPTH - 1) * step + 1;

    while (cyc < end_cyc) begin
      @(posedge sys_clk); #1;
      drive(cyc - s + 1);
      start      = 1'b0;
      abort      = (cyc == abort_cyc);
      trig_mode  = 2'($urandom);
      trig_level = DATA_W'($urandom);
      decim      = 8'($urandom);
      if (cyc == s + 1) begin
        check("busy_after_start", 64'(busy), 64'd1);
        check("sticky_cleared", 64'({trig_timeout, ovr_1, ovr_2}), 64'd0);
      end
    end

    if (rst_arm >= 0) begin
      check("busy_before_reset", 64'(busy), 64'd1);
      #2 sys_rst = 1'b1;
      #1 check("async_reset_outputs",
               64'({wr_en, wr_addr, wr_data, busy, done, trig_timeout, ovr_1, ovr_2}), 64'd0);
      exp_q.delete();
      done_q.delete();
      repeat (2) @(posedge sys_clk);
      #1 sys_rst = 1'b0;
    end else if (abort_addr >= 0) begin
      check("abort_wr_en", 64'(wr_en), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      repeat (4) @(posedge sys_clk);
      #1;
    end else begin
      check("busy_at_done", 64'(busy), 64'd0);
      check("trig_timeout", 64'(trig_timeout), 64'(forced));
      check("ovr_1", 64'(ovr_1), 64'(eo1));
      check("ovr_2", 64'(ovr_2), 64'(eo2));
    end
    @(posedge sys_clk); #1;
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    check("pending_done", 64'(done_q.size()), 64'd0);
  endtask

  initial begin
    sys_rst = 1'b1; start = 1'b0; abort = 1'b0;
    trig_mode = '0; trig_level = '0; decim = '0;
    ad_data_1 = '0; ad_data_2 = '0; ad_otr_1 = 1'b0; ad_otr_2 = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_outputs",
          64'({wr_en, wr_addr, wr_data, busy, done, trig_timeout, ovr_1, ovr_2}), 64'd0);
    sys_rst = 1'b0;

    // Immediate mode, no decimation, ramp data.
    fill(0);
    run_capture(2'd0, '0, 8'd0, -1, -1);
    check("ramp_last_addr_span", 64'(last_wr - first_wr), 64'(DEPTH - 1));

    // Rising trigger at 512 on a 500..530 sweep.
    fill(1);
    run_capture(2'd1, DATA_W'(512), 8'd0, -1, -1);
    check("rising_first_ch1", 64'(first_data[DATA_W-1:0]), 64'd512);

    // Rising mode that never crosses: forced trigger after TIMEOUT ARM cycles.
    fill(2);
    run_capture(2'd1, DATA_W'(512), 8'd0, -1, -1);
    check("forced_trigger_delay", 64'(first_wr - last_start), 64'(TIMEOUT + 1));
    check("forced_trig_timeout", 64'(trig_timeout), 64'd1);

    // Decimation by 4 in immediate mode (mode 3).
    fill(3);
    run_capture(2'd3, DATA_W'($urandom), 8'd3, -1, -1);
    check("decim3_span", 64'(last_wr - first_wr + 1), 64'd4093);

    // Single ch2 over-range pulse on a written sample.
    fill(0);
    potr2[400] = 1'b1;
    run_capture(2'd0, '0, 8'd0, -1, -1);
    check("ovr_2_set", 64'(ovr_2), 64'd1);
    check("ovr_1_clear", 64'(ovr_1), 64'd0);

    // Random configurations; each start also verifies the sticky flags are cleared.
    for (int r = 0; r < 3; r++) begin
      fill(3);
      run_capture(2'($urandom), DATA_W'($urandom), 8'($urandom_range(0, 2)), -1, -1);
    end

    // Falling trigger on random data.
    fill(3);
    run_capture(2'd2, DATA_W'(512), 8'd1, -1, -1);

    // Abort while address 300 is being written.
    fill(0);
    run_capture(2'd0, '0, 8'd0, 300, -1);

    // start and abort in the same IDLE cycle: capture must not begin.
    start = 1'b1; abort = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge sys_clk);
    #1 check("start_abort_busy_later", 64'({busy, wr_en}), 64'd0);

    // Asynchronous reset in the middle of ARM.
    fill(2);
    run_capture(2'd1, DATA_W'(512), 8'd0, -1, 10);

    // Normal capture after the reset.
    fill(3);
    run_capture(2'd0, '0, 8'd1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Sequences one acquisition from both 10-bit ADC channels. Both channels are sampled on the 100 MHz ADC clock domain.
- On start, arms a trigger on channel 1, then streams a fixed-length, optionally decimated block of paired samples into a sample buffer's write port.
- Reports completion, trigger timeout and out-of-range status to the measurement logic.
- Sits between the ADC pins (ad_data_x / ad_otr_x) and the capture RAM.

Parameters:
- DATA_W, 10, ADC sample width per channel.
- ADDR_W, 10, buffer address width; record length is 2**ADDR_W samples.
- TIMEOUT, 1000000, ARM-state cycles before a forced trigger (counter is 20 bits).

Ports:
- sys_clk  in  1  ADC-domain clock (100 MHz, same clock as ad_clk_x).
- sys_rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request to begin a capture.
- abort  in  1  single-cycle request to cancel the current capture.
- trig_mode  in  2  0=immediate, 1=ch1 rising, 2=ch1 falling, 3=immediate.
- trig_level  in  DATA_W  ch1 trigger threshold, unsigned.
- decim  in  8  keep 1 of every decim+1 samples.
- ad_data_1  in  DATA_W  channel 1 ADC data.
- ad_otr_1  in  1  channel 1 over-range.
- ad_data_2  in  DATA_W  channel 2 ADC data.
- ad_otr_2  in  1  channel 2 over-range.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W  buffer write address.
- wr_data  out  2*DATA_W  {ch2, ch1} sample pair.
- busy  out  1  high in ARM and CAPTURE.
- done  out  1  one-cycle pulse when a record completes.
- trig_timeout  out  1  sticky: last trigger was forced.
- ovr_1  out  1  sticky: a written ch1 sample had otr set.
- ovr_2  out  1  sticky: a written ch2 sample had otr set.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Input stage: ad_data_x and ad_otr_x are registered once (stage S1). The previous ch1 sample is held in S0 for edge detection.
- States: IDLE, ARM, CAPTURE, DONE.
- IDLE:
  - start (with abort low) latches trig_mode, trig_level and decim.
  - Clears trig_timeout, ovr_1, ovr_2 and the timeout counter.
  - Goes to ARM.
  - start in any other state is ignored.
- ARM:
  - Trigger condition, evaluated every cycle on S1:
    - mode 0/3: first ARM cycle.
    - rising: S0 < trig_level and S1 >= trig_level.
    - falling: S0 >= trig_level and S1 < trig_level.
  - The timeout counter increments each ARM cycle. At TIMEOUT-1 without a trigger, the trigger is forced and trig_timeout is set.
  - On trigger: the triggering S1 sample is written next cycle at wr_addr 0, and the state goes to CAPTURE.
- CAPTURE:
  - The decimation counter reloads to decim after each write and decrements each cycle.
  - A write occurs when the counter is 0, so writes are spaced decim+1 cycles apart. decim=0 writes every cycle.
  - wr_addr increments by 1 per write.
  - The write at address 2**ADDR_W-1 is the last; the state goes to DONE. The address never wraps within a record.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE.
- wr_en, wr_addr and wr_data are registered outputs.
  - Pin-to-wr_data latency is 2 cycles (S1 register plus output register).
  - wr_en is never high outside ARM→CAPTURE writes.
- ovr_x is set when a written sample carries otr=1. It stays set until the next accepted start.
- abort:
  - From ARM or CAPTURE, returns to IDLE next cycle.
  - wr_en is low from that cycle on; done is not pulsed.
  - Sticky flags are kept.
  - abort and start in the same IDLE cycle: abort wins, and the state stays IDLE.
- Asynchronous reset mid-capture immediately forces IDLE and zeroes all outputs. The partial record is discarded (no done).
- Comparison is unsigned on the full DATA_W. Equality with trig_level counts as "at/above".

Test Plan:
- Immediate mode, decim=0, ramp input ch1=n, ch2=1023-n:
  - 1024 consecutive wr_en cycles, addr 0..1023, wr_data={1023-n', n'}.
  - done is high exactly 1 cycle after the addr-1023 write; busy then falls.
- Rising mode, trig_level=512, ch1 sweeps 500→530 by 1/cycle:
  - First write (addr 0) carries ch1=512.
  - No wr_en before the trigger; trig_timeout=0.
- Rising mode, constant ch1=100, TIMEOUT set to 50 in bench:
  - Forced trigger after 50 ARM cycles; trig_timeout=1; record completes with done.
- decim=3, immediate mode:
  - Writes every 4th cycle; addresses increment by 1.
  - Total record spans 4093 cycles from first to last write.
- ad_otr_2 pulsed for one cycle during a written sample:
  - ovr_2=1 and ovr_1=0 after done.
  - The next start clears ovr_2 to 0.
- abort at addr 300 in CAPTURE:
  - wr_en low the next cycle; no done; busy=0.
  - start+abort together in IDLE keeps busy=0.
  - sys_rst mid-ARM zeroes all outputs asynchronously.
